mux_rr_n_ch: RTL and testbench

Parametrised N-channel, W-bit registered multiplexer with built-in arbitration and a valid/ready handshake on every port. It is the sequential successor to the two-way word multiplexer and the enable-gated tristate gate. Several producers share one downstream word bus through it: per cycle it picks at most one requesting channel, round-robin or fixed priority, and captures that channel's word into a single output register. The output drives the shared bus and can optionally float it when idle.

---
 rtl/mux_rr_n_ch.sv | 115 +++++++++++
 tb/tb_mux_rr_n_ch.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mux_rr_n_ch.sv
// N-channel registered word multiplexer with round-robin / fixed-priority
// arbitration. Define MUX_RR_TRISTATE_EN to float mux_out while idle.
module mux_rr_n_ch #(
  parameter int word_size = 32,
  parameter int num_ch = 4,
  localparam int sel_width = $clog2(num_ch)
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        mode,
  input  logic [num_ch-1:0]           req_valid,
  input  logic [num_ch*word_size-1:0] req_data,
  output logic [num_ch-1:0]           req_ready,
  output logic [word_size-1:0]        mux_out,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [sel_width-1:0]        grant_id
);

  localparam logic [sel_width:0] NCH =
    (sel_width+1)'(num_ch);
  localparam logic [sel_width-1:0] LAST =
    sel_width'(num_ch - 1);

  logic [sel_width-1:0] rr_ptr_q, rr_ptr_d;
  logic [sel_width-1:0] grant_q, grant_d;
  logic [word_size-1:0] data_q, data_d;
  logic                 out_valid_q, out_valid_d;

  logic [sel_width-1:0] win;
  logic                 any_req;
  logic                 can_load;
  logic                 accept;

  // Pick the winner: lowest index, or first set bit from rr_ptr upward.
  always_comb begin
    logic [sel_width:0]   sum;
    logic [sel_width-1:0] idx;
    win = '0;
    any_req = 1'b0;
    sum = '0;
    idx = '0;
    for (int k = 0; k < num_ch; k++) begin
      sum = {1'b0, rr_ptr_q} + (sel_width+1)'(k);
      if (sum >= NCH) begin
        sum = sum - NCH;
      end
      if (mode) begin
        idx = sel_width'(k);
      end else begin
        idx = sum[sel_width-1:0];
      end
      if (!any_req && req_valid[idx]) begin
        any_req = 1'b1;
        win = idx;
      end
    end
  end

  assign can_load = !out_valid_q || out_ready;
  assign accept = any_req && can_load && !reset;

  // One-hot ready toward the winning channel when the register can load.
  always_comb begin
    req_ready = '0;
    for (int i = 0; i < num_ch; i++) begin
      if (accept && (win == sel_width'(i))) begin
        req_ready[i] = 1'b1;
      end
    end
  end

  // Next state of the output register, grant and round-robin pointer.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    grant_d = grant_q;
    data_d = data_q;
    out_valid_d = out_valid_q;
    if (accept) begin
      data_d = req_data[int'(win)*word_size +: word_size];
      grant_d = win;
      out_valid_d = 1'b1;
      if (!mode) begin
        rr_ptr_d = (win == LAST) ? '0 : win + 1'b1;
      end
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // State registers with synchronous reset discarding any pending word.
  always_ff @(posedge clock) begin
    if (reset) begin
      rr_ptr_q <= '0;
      grant_q <= '0;
      data_q <= '0;
      out_valid_q <= 1'b0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      grant_q <= grant_d;
      data_q <= data_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_valid = out_valid_q;
  assign grant_id = grant_q;

`ifdef MUX_RR_TRISTATE_EN
  assign mux_out = out_valid_q ? data_q : {word_size{1'bz}};
`else
  assign mux_out = data_q;
`endif

endmodule

// File: tb/tb_mux_rr_n_ch.sv
// Bench for mux_rr_n_ch: 4x32 and 3x8 instances checked each cycle
// against a queue-free behavioural model plus literal expectations.
module tb_mux_rr_n_ch;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  int vec = 0;
  int bad = 0;

  // instance A: 4 x 32
  logic        a_mode = 1'b0;
  logic [3:0]  a_rv = '0;
  logic [127:0] a_rd = '0;
  logic [3:0]  a_rr;
  logic [31:0] a_mux;
  logic        a_ov;
  logic        a_ordy = 1'b0;
  logic [1:0]  a_gid;

  // instance B: 3 x 8
  logic        b_mode = 1'b0;
  logic [2:0]  b_rv = '0;
  logic [23:0] b_rd = '0;
  logic [2:0]  b_rr;
  logic [7:0]  b_mux;
  logic        b_ov;
  logic        b_ordy = 1'b0;
  logic [1:0]  b_gid;

  mux_rr_n_ch #(.word_size(32), .num_ch(4)) u_a (
    .clock(clock), .reset(reset), .mode(a_mode),
    .req_valid(a_rv), .req_data(a_rd), .req_ready(a_rr),
    .mux_out(a_mux), .out_valid(a_ov), .out_ready(a_ordy),
    .grant_id(a_gid)
  );

  mux_rr_n_ch #(.word_size(8), .num_ch(3)) u_b (
    .clock(clock), .reset(reset), .mode(b_mode),
    .req_valid(b_rv), .req_data(b_rd), .req_ready(b_rr),
    .mux_out(b_mux), .out_valid(b_ov), .out_ready(b_ordy),
    .grant_id(b_gid)
  );

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    vec++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask

  // Spec rule: which channel wins, -1 if nobody requests.
  function automatic int arb(input int n, input logic [15:0] v,
                             input logic m, input int ptr);
    int c;
    for (int k = 0; k < n; k++) begin
      c = m ? k : (ptr + k) % n;
      if (v[c]) return c;
    end
    return -1;
  endfunction

  // model state
  int          ma_ptr = 0, ma_gid = 0;
  logic        ma_v = 1'b0;
  logic [31:0] ma_d = '0;
  int          mb_ptr = 0, mb_gid = 0;
  logic        mb_v = 1'b0;
  logic [7:0]  mb_d = '0;

  always @(posedge clock) begin
    int w;
    if (reset) begin
      ma_ptr = 0; ma_gid = 0; ma_v = 1'b0; ma_d = '0;
      mb_ptr = 0; mb_gid = 0; mb_v = 1'b0; mb_d = '0;
    end else begin
      w = arb(4, 16'(a_rv), a_mode, ma_ptr);
      if (w >= 0 && (!ma_v || a_ordy)) begin
        ma_d = a_rd[w*32 +: 32]; ma_gid = w; ma_v = 1'b1;
        if (!a_mode) ma_ptr = (w + 1) % 4;
      end else if (a_ordy) ma_v = 1'b0;
      w = arb(3, 16'(b_rv), b_mode, mb_ptr);
      if (w >= 0 && (!mb_v || b_ordy)) begin
        mb_d = b_rd[w*8 +: 8]; mb_gid = w; mb_v = 1'b1;
        if (!b_mode) mb_ptr = (w + 1) % 3;
      end else if (b_ordy) mb_v = 1'b0;
    end
  end

  // compare process: every cycle, away from the active edge
  always @(negedge clock) begin
    int w;
    logic [3:0]  era;
    logic [2:0]  erb;
    logic [31:0] ema;
    logic [7:0]  emb;
    w = arb(4, 16'(a_rv), a_mode, ma_ptr);
    era = (reset || w < 0 || (ma_v && !a_ordy)) ? 4'd0 : 4'(1 << w);
    w = arb(3, 16'(b_rv), b_mode, mb_ptr);
    erb = (reset || w < 0 || (mb_v && !b_ordy)) ? 3'd0 : 3'(1 << w);
`ifdef MUX_RR_TRISTATE_EN
    ema = ma_v ? ma_d : 'z;
    emb = mb_v ? mb_d : 'z;
`else
    ema = ma_d;
    emb = mb_d;
`endif
    chk("a.req_ready", 64'(a_rr), 64'(era));
    chk("a.out_valid", 64'(a_ov), 64'(ma_v));
    chk("a.grant_id", 64'(a_gid), 64'(ma_gid));
    chk("a.mux_out", 64'(a_mux), 64'(ema));
    chk("b.req_ready", 64'(b_rr), 64'(erb));
    chk("b.out_valid", 64'(b_ov), 64'(mb_v));
    chk("b.grant_id", 64'(b_gid), 64'(mb_gid));
    chk("b.mux_out", 64'(b_mux), 64'(emb));
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic amux(input string nm, input logic [31:0] d,
                      input logic v);
`ifdef MUX_RR_TRISTATE_EN
    chk(nm, 64'(a_mux), v ? 64'(d) : 64'(32'hzzzz_zzzz));
`else
    chk(nm, 64'(a_mux), 64'(d));
`endif
  endtask

  initial begin
    int ga [5];
    logic [7:0] eb [4];
    ga = '{0, 1, 2, 3, 0};
    eb = '{8'hA0, 8'hA1, 8'hA2, 8'hA0};

    step(); step();
    reset = 1'b0;
    chk("rst.out_valid", 64'(a_ov), 64'd0);
    chk("rst.grant_id", 64'(a_gid), 64'd0);
    amux("rst.mux_out", 32'd0, 1'b0);

    // reset mid-stall
    a_rv = 4'b0001;
    a_rd[31:0] = 32'h1111_1111;
    a_rd[127:96] = 32'h3333_3333;
    step();
    a_rv = '0;
    chk("load.out_valid", 64'(a_ov), 64'd1);
    amux("load.mux_out", 32'h1111_1111, 1'b1);
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("midrst.out_valid", 64'(a_ov), 64'd0);
    chk("midrst.grant_id", 64'(a_gid), 64'd0);
    amux("midrst.mux_out", 32'd0, 1'b0);
    a_rv = 4'b1000;
    a_ordy = 1'b1;
    step();
    a_rv = '0;
    chk("postrst.grant_id", 64'(a_gid), 64'd3);
    amux("postrst.mux_out", 32'h3333_3333, 1'b1);
    step();

    // round-robin fairness
    for (int i = 0; i < 4; i++) a_rd[i*32 +: 32] = 32'hF000_0000 + i;
    a_rv = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      step();
      chk("rr.grant_id", 64'(a_gid), 64'(ga[k]));
      chk("rr.out_valid", 64'(a_ov), 64'd1);
    end
    a_rv = 4'b0010;
    step();
    chk("rr.ptr_to_2", 64'(a_gid), 64'd1);
    a_rv = '0;
    step();

    // fixed priority, then back to round-robin
    a_mode = 1'b1;
    a_rv = 4'b1010;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("fix.grant_id", 64'(a_gid), 64'd1);
    end
    a_mode = 1'b0;
    step();
    chk("fix2rr.first", 64'(a_gid), 64'd3);
    step();
    chk("fix2rr.second", 64'(a_gid), 64'd1);
    a_rv = '0;
    step();

    // backpressure
    a_ordy = 1'b0;
    a_rv = 4'b0101;
    step();
    a_rv = 4'b0001;
    chk("bp.grant_id", 64'(a_gid), 64'd2);
    for (int k = 0; k < 5; k++) begin
      step();
      chk("bp.stall_grant", 64'(a_gid), 64'd2);
      amux("bp.stall_mux", 32'hF000_0002, 1'b1);
      chk("bp.stall_ready", 64'(a_rr), 64'd0);
    end
    a_ordy = 1'b1;
    step();
    a_rv = '0;
    chk("bp.release_grant", 64'(a_gid), 64'd0);
    chk("bp.release_valid", 64'(a_ov), 64'd1);
    amux("bp.release_mux", 32'hF000_0000, 1'b1);
    step();
    chk("bp.drained", 64'(a_ov), 64'd0);

    // mixed traffic, model-checked
    for (int k = 0; k < 40; k++) begin
      a_rv = 4'($urandom);
      a_mode = 1'($urandom);
      a_ordy = 1'($urandom);
      a_rd = {$urandom, $urandom, $urandom, $urandom};
      step();
    end
    a_rv = '0;
    a_ordy = 1'b1;

    // non-power-of-2 wrap on instance B
    b_rd = {8'hA2, 8'hA1, 8'hA0};
    b_rv = 3'b111;
    b_ordy = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      chk("wrap.mux_out", 64'(b_mux), 64'(eb[k]));
      chk("wrap.grant_lt3", 64'(b_gid < 2'd3), 64'd1);
    end
    b_rv = '0;
    step();
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
    $finish;
  end

endmodule
